// File: rtl/song_reader_pkg.sv
// Shared definitions for the song sequencer.
// Purpose: field widths, word layout helpers and the sequencer state encoding
//          used by song_reader and anything that builds song_rom images.
// Contents:
//   NOTE_W/DUR_W/SONG_W/IDX_W   field widths
//   WORD_W/ADDR_W               derived rom word and address widths
//   REST_NOTE/END_DUR           special field values
//   state_t                     sequencer states
//   word_note/word_dur          slice a {note,dur} rom word
package song_reader_pkg;

  localparam int NOTE_W = 6;
  localparam int DUR_W  = 6;
  localparam int SONG_W = 2;
  localparam int IDX_W  = 5;

  localparam int WORD_W = NOTE_W + DUR_W;
  localparam int ADDR_W = SONG_W + IDX_W;

  localparam logic [NOTE_W-1:0] REST_NOTE = '0;
  localparam logic [DUR_W-1:0]  END_DUR   = '0;
  localparam logic [IDX_W-1:0]  LAST_IDX  = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_PLAY,
    ST_DONE
  } state_t;

  // Upper field of a rom word is the note code
  function automatic logic [NOTE_W-1:0] word_note(input logic [WORD_W-1:0] w);
    return w[WORD_W-1:DUR_W];
  endfunction

  // Lower field of a rom word is the duration in beats
  function automatic logic [DUR_W-1:0] word_dur(input logic [WORD_W-1:0] w);
    return w[DUR_W-1:0];
  endfunction

endpackage

// File: rtl/song_reader.sv
// song_reader: plays one song out of song_rom, one {note,dur} word at a time.
// Each note is presented for dur beat ticks, then the next word is fetched.
// A zero duration marks the end of the song; entry 31 also ends it.
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   play       level: 1 = play/resume, 0 = pause (or re-arm after done)
//   song_sel   song to play; sampled in idle, a change while busy restarts
//   beat       one-cycle tempo tick
//   rom_addr   registered address {song, idx} to song_rom
//   rom_dout   song_rom data, valid one cycle after rom_addr
//   note       current note code, held until the next word loads
//   note_valid high while a non-rest note sounds and play is high
//   new_note   one-cycle pulse when a word (note or rest) loads
//   song_done  one-cycle pulse at end of song
//   busy       high in every state except idle
module song_reader
  import song_reader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              play,
  input  logic [SONG_W-1:0] song_sel,
  input  logic              beat,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [WORD_W-1:0] rom_dout,
  output logic [NOTE_W-1:0] note,
  output logic              note_valid,
  output logic              new_note,
  output logic              song_done,
  output logic              busy
);

  state_t              state;
  logic [SONG_W-1:0]   cur_song;
  logic [IDX_W-1:0]    idx;
  logic [DUR_W-1:0]    dur;
  logic [DUR_W-1:0]    beat_cnt;
  // Remembers that the loaded word is a real note, so note_valid can be
  // restored after a pause while fetching the following word.
  logic                sounding;

  logic                song_change;
  logic                beat_last;
  logic [IDX_W-1:0]    idx_next;
  logic [NOTE_W-1:0]   load_note;
  logic [DUR_W-1:0]    load_dur;

  // A song_sel change is only watched while a song is actually being read;
  // in idle it is simply sampled and in done it is ignored until re-arm.
  always_comb begin
    song_change = (state == ST_FETCH || state == ST_WAIT || state == ST_PLAY)
                  && (song_sel != cur_song);
    beat_last   = (beat_cnt == dur - DUR_W'(1));
    idx_next    = idx + IDX_W'(1);
    load_note   = word_note(rom_dout);
    load_dur    = word_dur(rom_dout);
  end

  // Sequencer. Priority is song change, then pause (play=0 freezes
  // everything except note_valid), then beat handling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cur_song   <= '0;
      idx        <= '0;
      dur        <= '0;
      beat_cnt   <= '0;
      sounding   <= 1'b0;
      rom_addr   <= '0;
      note       <= '0;
      note_valid <= 1'b0;
      new_note   <= 1'b0;
      song_done  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      new_note  <= 1'b0;
      song_done <= 1'b0;
      if (song_change) begin
        cur_song   <= song_sel;
        idx        <= '0;
        rom_addr   <= {song_sel, {IDX_W{1'b0}}};
        beat_cnt   <= '0;
        sounding   <= 1'b0;
        note_valid <= 1'b0;
        busy       <= 1'b1;
        state      <= ST_FETCH;
      end else begin
        case (state)
          ST_IDLE: begin
            note_valid <= 1'b0;
            if (play) begin
              cur_song <= song_sel;
              idx      <= '0;
              rom_addr <= {song_sel, {IDX_W{1'b0}}};
              busy     <= 1'b1;
              state    <= ST_FETCH;
            end
          end
          // The previous note keeps sounding while the next word is fetched
          ST_FETCH: begin
            note_valid <= play && sounding;
            if (play) state <= ST_WAIT;
          end
          ST_WAIT: begin
            if (!play) begin
              note_valid <= 1'b0;
            end else if (load_dur == END_DUR) begin
              sounding   <= 1'b0;
              note_valid <= 1'b0;
              song_done  <= 1'b1;
              state      <= ST_DONE;
            end else begin
              note       <= load_note;
              dur        <= load_dur;
              beat_cnt   <= '0;
              sounding   <= (load_note != REST_NOTE);
              note_valid <= (load_note != REST_NOTE);
              new_note   <= 1'b1;
              state      <= ST_PLAY;
            end
          end
          ST_PLAY: begin
            if (!play) begin
              note_valid <= 1'b0;
            end else begin
              note_valid <= sounding;
              if (beat) begin
                if (!beat_last) begin
                  beat_cnt <= beat_cnt + DUR_W'(1);
                end else if (idx == LAST_IDX) begin
                  sounding   <= 1'b0;
                  note_valid <= 1'b0;
                  song_done  <= 1'b1;
                  state      <= ST_DONE;
                end else begin
                  idx      <= idx_next;
                  rom_addr <= {cur_song, idx_next};
                  state    <= ST_FETCH;
                end
              end
            end
          end
          // Wait for play to drop so a finished song does not loop
          ST_DONE: begin
            note_valid <= 1'b0;
            if (!play) begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end
          end
          default: begin
            note_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_song_reader.sv
// Testbench for song_reader with a behavioural song_rom beside it.
module tb_song_reader;
  import song_reader_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              play;
  logic [SONG_W-1:0] song_sel;
  logic              beat;
  logic [ADDR_W-1:0] rom_addr;
  logic [WORD_W-1:0] rom_dout;
  logic [NOTE_W-1:0] note;
  logic              note_valid;
  logic              new_note;
  logic              song_done;
  logic              busy;

  logic [WORD_W-1:0] rom [128];

  int vectors;
  int miscompares;

  typedef struct {
    logic       play;
    logic [1:0] sel;
    logic       beat;
    logic [6:0] addr;
    logic [5:0] note;
    logic       nv;
    logic       nn;
    logic       sd;
    logic       busy;
  } vec_t;

  vec_t vecs [8];

  song_reader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .play       (play),
    .song_sel   (song_sel),
    .beat       (beat),
    .rom_addr   (rom_addr),
    .rom_dout   (rom_dout),
    .note       (note),
    .note_valid (note_valid),
    .new_note   (new_note),
    .song_done  (song_done),
    .busy       (busy)
  );

  // Clock with period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // song_rom model: one-cycle registered read
  always_ff @(posedge clk) rom_dout <= rom[rom_addr];

  // Hard stop in case a loop bound is somehow bypassed
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [WORD_W-1:0] mk(input int n, input int d);
    logic [5:0] nn;
    logic [5:0] dd;
    nn = n[5:0];
    dd = d[5:0];
    return {nn, dd};
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive inputs at the falling edge, let one rising edge act, return at the next falling edge
  task automatic applyStimulus(input logic p, input logic [1:0] s, input logic b);
    play     = p;
    song_sel = s;
    beat     = b;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkAll(input string tag, input int a, input int n, input int nv,
                          input int nn, input int sd, input int bz);
    checkOutput({tag, ".rom_addr"},   int'(rom_addr),   a);
    checkOutput({tag, ".note"},       int'(note),       n);
    checkOutput({tag, ".note_valid"}, int'(note_valid), nv);
    checkOutput({tag, ".new_note"},   int'(new_note),   nn);
    checkOutput({tag, ".song_done"},  int'(song_done),  sd);
    checkOutput({tag, ".busy"},       int'(busy),       bz);
  endtask

  initial begin
    int beats;
    int nn_count;
    int guard;
    int nv_seen;

    vectors     = 0;
    miscompares = 0;

    for (int i = 0; i < 128; i++) begin
      int s;
      int k;
      s = i / 32;
      k = i % 32;
      case (s)
        0: rom[i] = (k < 28) ? mk(k + 1, 1) : ((k == 28) ? mk(37, 0) : mk(1, 1));
        1: rom[i] = mk(k + 10, 3);
        2: rom[i] = mk(20 + (k % 8), 2);
        default: rom[i] = mk(30, 1);
      endcase
    end
    rom[32]  = mk(35, 36);
    rom[33]  = mk(42, 2);
    rom[34]  = mk(38, 54);
    rom[64]  = mk(5, 1);
    rom[65]  = mk(6, 1);
    rom[66]  = mk(0, 34);
    rom[70]  = mk(9, 40);
    rom[96]  = mk(28, 12);
    rom[127] = mk(45, 12);

    // play, sel, beat -> addr, note, nv, nn, sd, busy
    vecs[0] = '{1'b1, 2'd1, 1'b0, 7'd32, 6'd0,  1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 2'd1, 1'b0, 7'd32, 6'd0,  1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 2'd1, 1'b0, 7'd32, 6'd35, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 2'd1, 1'b1, 7'd32, 6'd35, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 2'd1, 1'b1, 7'd32, 6'd35, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 2'd1, 1'b0, 7'd32, 6'd35, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 2'd1, 1'b0, 7'd32, 6'd35, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 2'd1, 1'b1, 7'd32, 6'd35, 1'b1, 1'b0, 1'b0, 1'b1};

    rst_n    = 1'b0;
    play     = 1'b0;
    song_sel = '0;
    beat     = 1'b0;
    repeat (3) @(negedge clk);
    checkAll("reset", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Song 1 start, first beats and a short pause (beat_cnt ends at 2)
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].play, vecs[i].sel, vecs[i].beat);
      checkAll($sformatf("vec%0d", i), int'(vecs[i].addr), int'(vecs[i].note),
               int'(vecs[i].nv), int'(vecs[i].nn), int'(vecs[i].sd), int'(vecs[i].busy));
    end

    // Remaining 34 beats of note 35, one beat every 4 clocks
    beats = 0;
    while (rom_addr == 7'd32 && beats < 100) begin
      applyStimulus(1'b1, 2'd1, 1'b1);
      beats++;
      if (rom_addr == 7'd32) repeat (3) applyStimulus(1'b1, 2'd1, 1'b0);
    end
    checkOutput("n35.beats", beats, 34);
    checkOutput("n35.next_addr", int'(rom_addr), 33);
    checkOutput("n35.hold_note", int'(note), 35);
    checkOutput("n35.hold_valid", int'(note_valid), 1);
    applyStimulus(1'b1, 2'd1, 1'b0);
    checkOutput("n42.wait_nn", int'(new_note), 0);
    applyStimulus(1'b1, 2'd1, 1'b0);
    checkOutput("n42.new_note", int'(new_note), 1);
    checkOutput("n42.note", int'(note), 42);

    // Entry 33 lasts 2 beats, then entry 34 (note 38, dur 54)
    applyStimulus(1'b1, 2'd1, 1'b1);
    applyStimulus(1'b1, 2'd1, 1'b1);
    checkOutput("n38.addr", int'(rom_addr), 34);
    applyStimulus(1'b1, 2'd1, 1'b0);
    applyStimulus(1'b1, 2'd1, 1'b0);
    checkOutput("n38.new_note", int'(new_note), 1);
    checkOutput("n38.note", int'(note), 38);
    repeat (10) applyStimulus(1'b1, 2'd1, 1'b1);
    checkOutput("n38.valid_before_pause", int'(note_valid), 1);
    repeat (20) applyStimulus(1'b0, 2'd1, 1'b1);
    checkAll("pause", 34, 38, 0, 0, 0, 1);
    beats = 0;
    while (rom_addr == 7'd34 && beats < 100) begin
      applyStimulus(1'b1, 2'd1, 1'b1);
      beats++;
    end
    checkOutput("resume.beats", beats, 44);
    checkOutput("resume.next_addr", int'(rom_addr), 35);

    // Load entry 35 (idx 3), then reset asynchronously mid-cycle
    applyStimulus(1'b1, 2'd1, 1'b0);
    applyStimulus(1'b1, 2'd1, 1'b0);
    checkOutput("idx3.new_note", int'(new_note), 1);
    checkOutput("idx3.note", int'(note), 13);
    #2;
    rst_n = 1'b0;
    play  = 1'b0;
    #1;
    checkAll("async_reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 2'd1, 1'b0);
    checkOutput("post_reset.addr", int'(rom_addr), 32);
    checkOutput("post_reset.busy", int'(busy), 1);

    // Song change from FETCH restarts at song 0
    applyStimulus(1'b1, 2'd0, 1'b0);
    checkOutput("chg0.addr", int'(rom_addr), 0);
    checkOutput("chg0.valid", int'(note_valid), 0);

    // Song 0 runs through entry 27 and ends on the marker at addr 28
    nn_count = 0;
    guard    = 0;
    while (!song_done && guard < 300) begin
      applyStimulus(1'b1, 2'd0, 1'b1);
      if (new_note) nn_count++;
      guard++;
    end
    checkOutput("s0.done_pulse", int'(song_done), 1);
    checkOutput("s0.words", nn_count, 28);
    checkOutput("s0.addr", int'(rom_addr), 28);
    checkOutput("s0.valid", int'(note_valid), 0);
    checkOutput("s0.note_hold", int'(note), 28);
    repeat (3) applyStimulus(1'b1, 2'd0, 1'b1);
    checkAll("s0.done_hold", 28, 28, 0, 0, 0, 1);
    applyStimulus(1'b0, 2'd0, 1'b0);
    checkOutput("s0.idle_busy", int'(busy), 0);

    // Song 2: rest word at addr 66
    guard = 0;
    while (!(new_note && rom_addr == 7'd66) && guard < 100) begin
      applyStimulus(1'b1, 2'd2, 1'b1);
      guard++;
    end
    checkOutput("rest.new_note", int'(new_note), 1);
    checkOutput("rest.note", int'(note), 0);
    checkOutput("rest.valid", int'(note_valid), 0);
    beats   = 0;
    nv_seen = 0;
    while (rom_addr == 7'd66 && beats < 100) begin
      applyStimulus(1'b1, 2'd2, 1'b1);
      beats++;
      if (note_valid) nv_seen++;
    end
    checkOutput("rest.beats", beats, 34);
    checkOutput("rest.valid_cycles", nv_seen, 0);

    // Reach addr 70 then switch to song 3
    guard = 0;
    while (!(new_note && rom_addr == 7'd70) && guard < 100) begin
      applyStimulus(1'b1, 2'd2, 1'b1);
      guard++;
    end
    checkOutput("a70.note", int'(note), 9);
    checkOutput("a70.valid", int'(note_valid), 1);
    repeat (3) applyStimulus(1'b1, 2'd2, 1'b1);
    applyStimulus(1'b1, 2'd3, 1'b1);
    checkAll("chg3", 96, 9, 0, 0, 0, 1);
    applyStimulus(1'b1, 2'd3, 1'b1);
    checkOutput("chg3.wait_nn", int'(new_note), 0);
    applyStimulus(1'b1, 2'd3, 1'b1);
    checkAll("chg3.load", 96, 28, 1, 1, 0, 1);
    beats = 0;
    while (rom_addr == 7'd96 && beats < 100) begin
      applyStimulus(1'b1, 2'd3, 1'b1);
      beats++;
    end
    checkOutput("n28.beats", beats, 12);

    // Last entry of song 3 ends the song after its 12 beats
    guard = 0;
    while (!(new_note && rom_addr == 7'd127) && guard < 200) begin
      applyStimulus(1'b1, 2'd3, 1'b1);
      guard++;
    end
    checkOutput("a127.note", int'(note), 45);
    beats = 0;
    while (!song_done && beats < 100) begin
      applyStimulus(1'b1, 2'd3, 1'b1);
      beats++;
    end
    checkOutput("a127.beats", beats, 12);
    checkAll("a127.done", 127, 45, 0, 0, 1, 1);
    applyStimulus(1'b1, 2'd3, 1'b0);
    checkAll("a127.done_hold", 127, 45, 0, 0, 0, 1);
    applyStimulus(1'b0, 2'd3, 1'b0);
    checkOutput("a127.idle_busy", int'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
